// File: rtl/mole_field_if.sv
// Bundles the game-side signals of the mole field controller: selector, game
// timing, buttons in; LEDs, score pulses and the UP-hole count out.
interface mole_field_if #(
    parameter int NUM_HOLES = 10,
    parameter int SEL_W     = 4
) ();
    logic                 tick;
    logic [1:0]           mode;
    logic [SEL_W-1:0]     sel;
    logic                 spawn;
    logic [NUM_HOLES-1:0] btn;
    logic [NUM_HOLES-1:0] led;
    logic                 hit;
    logic                 miss;
    logic                 whiff;
    logic [SEL_W-1:0]     active_cnt;

    modport master (
        output tick, mode, sel, spawn, btn,
        input  led, hit, miss, whiff, active_cnt
    );

    modport slave (
        input  tick, mode, sel, spawn, btn,
        output led, hit, miss, whiff, active_cnt
    );
endinterface

// File: rtl/mole_field_ctrl.sv
// Per-hole DOWN/UP/FLASH mole controller driving NUM_HOLES LEDs with hit/miss pulses.
// Optional button-on-empty-hole pulse is enabled by defining MOLE_WHIFF_PENALTY_EN.
module mole_field_ctrl #(
    parameter int NUM_HOLES   = 10,
    parameter int SEL_W       = 4,
    parameter int POP_TICKS   = 8,
    parameter int FLASH_TICKS = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    mole_field_if.slave  bus
);
    localparam int TMAX = (POP_TICKS > FLASH_TICKS) ? POP_TICKS : FLASH_TICKS;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {ST_DOWN, ST_UP, ST_FLASH} hole_st_e;

    hole_st_e             state_q [NUM_HOLES];
    hole_st_e             state_d [NUM_HOLES];
    logic [TW-1:0]        timer_q [NUM_HOLES];
    logic [TW-1:0]        timer_d [NUM_HOLES];
    logic [NUM_HOLES-1:0] phase_q, phase_d;
    logic [NUM_HOLES-1:0] led_q, led_d;
    logic                 hit_q, hit_d;
    logic                 miss_q, miss_d;
    logic [SEL_W-1:0]     cnt_q, cnt_d;
    logic                 mode_play_s;
    logic                 mode_freeze_s;
    logic                 spawn_ok_s;

    assign mode_play_s   = (bus.mode == 2'b01);
    assign mode_freeze_s = (bus.mode == 2'b10);
    assign spawn_ok_s    = bus.spawn && (bus.sel != SEL_W'(0)) && (bus.sel <= SEL_W'(NUM_HOLES));

    // Next state of every hole plus the derived LED image, pulses and UP count.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        phase_d = phase_q;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
        led_d   = '0;
        cnt_d   = '0;
        for (int i = 0; i < NUM_HOLES; i++) begin
            if (mode_play_s) begin
                case (state_q[i])
                    ST_DOWN: begin
                        if (spawn_ok_s && (bus.sel == SEL_W'(i + 1))) begin
                            state_d[i] = ST_UP;
                            timer_d[i] = TW'(POP_TICKS);
                        end else begin
                            state_d[i] = ST_DOWN;
                        end
                    end
                    ST_UP: begin
                        // A hit takes priority over an expiry in the same cycle.
                        if (bus.btn[i]) begin
                            state_d[i] = ST_FLASH;
                            timer_d[i] = TW'(FLASH_TICKS);
                            phase_d[i] = 1'b1;
                            hit_d      = 1'b1;
                        end else if (bus.tick && (timer_q[i] == TW'(1))) begin
                            state_d[i] = ST_DOWN;
                            timer_d[i] = TW'(0);
                            miss_d     = 1'b1;
                        end else if (bus.tick) begin
                            timer_d[i] = timer_q[i] - TW'(1);
                        end else begin
                            timer_d[i] = timer_q[i];
                        end
                    end
                    ST_FLASH: begin
                        if (bus.tick && (timer_q[i] == TW'(1))) begin
                            state_d[i] = ST_DOWN;
                            timer_d[i] = TW'(0);
                            phase_d[i] = 1'b0;
                        end else if (bus.tick) begin
                            timer_d[i] = timer_q[i] - TW'(1);
                            phase_d[i] = ~phase_q[i];
                        end else begin
                            timer_d[i] = timer_q[i];
                        end
                    end
                    default: begin
                        state_d[i] = ST_DOWN;
                        timer_d[i] = TW'(0);
                        phase_d[i] = 1'b0;
                    end
                endcase
                led_d[i] = (state_d[i] == ST_UP) || ((state_d[i] == ST_FLASH) && phase_d[i]);
            end else if (mode_freeze_s) begin
                led_d[i] = 1'b0;
            end else begin
                state_d[i] = ST_DOWN;
                timer_d[i] = TW'(0);
                phase_d[i] = 1'b0;
                led_d[i]   = 1'b1;
            end
            if (state_d[i] == ST_UP) begin
                cnt_d = cnt_d + SEL_W'(1);
            end else begin
                cnt_d = cnt_d;
            end
        end
    end

    // Hole state, timers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_HOLES; i++) begin
                state_q[i] <= ST_DOWN;
                timer_q[i] <= TW'(0);
            end
            phase_q <= '0;
            led_q   <= '0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_HOLES; i++) begin
                state_q[i] <= state_d[i];
                timer_q[i] <= timer_d[i];
            end
            phase_q <= phase_d;
            led_q   <= led_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef MOLE_WHIFF_PENALTY_EN
    logic whiff_q, whiff_d;

    // Any button on a hole that is not UP counts as a whiff, independent of hits elsewhere.
    always_comb begin
        whiff_d = 1'b0;
        if (mode_play_s) begin
            for (int i = 0; i < NUM_HOLES; i++) begin
                whiff_d = whiff_d | (bus.btn[i] && (state_q[i] != ST_UP));
            end
        end else begin
            whiff_d = 1'b0;
        end
    end

    // Whiff pulse register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            whiff_q <= 1'b0;
        end else begin
            whiff_q <= whiff_d;
        end
    end

    assign bus.whiff = whiff_q;
`else
    assign bus.whiff = 1'b0;
`endif

    assign bus.led        = led_q;
    assign bus.hit        = hit_q;
    assign bus.miss       = miss_q;
    assign bus.active_cnt = cnt_q;
endmodule

// File: tb/tb_mole_field_ctrl.sv
// Directed self-checking bench for mole_field_ctrl with hand-computed expectations.
module tb_mole_field_ctrl;
    localparam int NH = 10;
    localparam int SW = 4;
`ifdef MOLE_WHIFF_PENALTY_EN
    localparam logic WHIFF_EXP = 1'b1;
`else
    localparam logic WHIFF_EXP = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    mole_field_if #(.NUM_HOLES(NH), .SEL_W(SW)) bus ();

    mole_field_ctrl #(
        .NUM_HOLES(NH), .SEL_W(SW), .POP_TICKS(8), .FLASH_TICKS(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs; outputs are read 1 ns after the edge.
    task automatic step(input logic tk, input logic sp, input logic [SW-1:0] s, input logic [NH-1:0] b);
        bus.tick  = tk;
        bus.spawn = sp;
        bus.sel   = s;
        bus.btn   = b;
        @(posedge clk);
        #1;
        bus.tick  = 1'b0;
        bus.spawn = 1'b0;
        bus.btn   = '0;
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        bus.mode  = 2'b01;
        bus.tick  = 1'b0;
        bus.spawn = 1'b0;
        bus.sel   = '0;
        bus.btn   = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_led", bus.led, 0);
        check_eq("rst_cnt", bus.active_cnt, 0);
        check_eq("rst_pulses", {bus.hit, bus.miss, bus.whiff}, 0);
        rst_n = 1'b1;

        // Plain expiry of hole 3 after 8 ticks.
        step(1'b0, 1'b1, 4'd3, '0);
        check_eq("spawn3_led", bus.led, 10'h004);
        check_eq("spawn3_cnt", bus.active_cnt, 1);
        for (int k = 0; k < 7; k++) begin
            step(1'b1, 1'b0, 4'd0, '0);
            check_eq("up3_led", bus.led, 10'h004);
            check_eq("up3_miss", bus.miss, 0);
        end
        step(1'b1, 1'b0, 4'd0, '0);
        check_eq("exp3_led", bus.led, 0);
        check_eq("exp3_miss", bus.miss, 1);
        check_eq("exp3_cnt", bus.active_cnt, 0);
        step(1'b0, 1'b0, 4'd0, '0);
        check_eq("exp3_miss_once", bus.miss, 0);

        // Hit on the expiring tick: hit wins, hole 3 flashes.
        step(1'b0, 1'b1, 4'd3, '0);
        for (int k = 0; k < 7; k++) step(1'b1, 1'b0, 4'd0, '0);
        step(1'b1, 1'b0, 4'd0, 10'h004);
        check_eq("tie_hit", bus.hit, 1);
        check_eq("tie_miss", bus.miss, 0);
        check_eq("tie_led", bus.led, 10'h004);
        check_eq("tie_cnt", bus.active_cnt, 0);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, 4'd0, '0);
            check_eq("tie_flash_led", bus.led, (k == 1) ? 10'h004 : 10'h000);
        end

        // Hit on hole 5 after two ticks, then 4 flash ticks.
        step(1'b0, 1'b1, 4'd5, '0);
        check_eq("spawn5_led", bus.led, 10'h010);
        step(1'b1, 1'b0, 4'd0, '0);
        step(1'b1, 1'b0, 4'd0, '0);
        step(1'b0, 1'b0, 4'd0, 10'h010);
        check_eq("hit5", bus.hit, 1);
        check_eq("hit5_led", bus.led, 10'h010);
        check_eq("hit5_cnt", bus.active_cnt, 0);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, 4'd0, '0);
            check_eq("flash5_led", bus.led, (k == 1) ? 10'h010 : 10'h000);
            check_eq("flash5_pulses", {bus.hit, bus.miss}, 0);
        end

        // Ignored spawns: invalid selects and an already-UP hole.
        step(1'b0, 1'b1, 4'd3, '0);
        check_eq("re3_led", bus.led, 10'h004);
        step(1'b0, 1'b1, 4'd0, '0);
        check_eq("sel0_led", bus.led, 10'h004);
        check_eq("sel0_cnt", bus.active_cnt, 1);
        step(1'b0, 1'b1, 4'd11, '0);
        check_eq("sel11_led", bus.led, 10'h004);
        check_eq("sel11_cnt", bus.active_cnt, 1);
        step(1'b0, 1'b1, 4'd3, '0);
        check_eq("dup3_cnt", bus.active_cnt, 1);

        // Two moles up, freeze for several ticks, then resume with timers intact.
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 4'd0, '0);
        step(1'b0, 1'b1, 4'd7, '0);
        check_eq("two_led", bus.led, 10'h044);
        check_eq("two_cnt", bus.active_cnt, 2);
        bus.mode = 2'b10;
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b0, 4'd0, '0);
            check_eq("frz_led", bus.led, 0);
            check_eq("frz_cnt", bus.active_cnt, 2);
            check_eq("frz_miss", bus.miss, 0);
        end
        step(1'b1, 1'b1, 4'd9, 10'h004);
        check_eq("frz_hit", bus.hit, 0);
        bus.mode = 2'b01;
        step(1'b0, 1'b0, 4'd0, '0);
        check_eq("resume_led", bus.led, 10'h044);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, 4'd0, '0);
            check_eq("resume_up_led", bus.led, 10'h044);
        end
        step(1'b1, 1'b0, 4'd0, '0);
        check_eq("resume_exp3_led", bus.led, 10'h040);
        check_eq("resume_exp3_miss", bus.miss, 1);
        check_eq("resume_exp3_cnt", bus.active_cnt, 1);
        step(1'b1, 1'b0, 4'd0, '0);
        step(1'b1, 1'b0, 4'd0, '0);
        check_eq("resume_up7_led", bus.led, 10'h040);
        step(1'b1, 1'b0, 4'd0, '0);
        check_eq("resume_exp7_led", bus.led, 0);
        check_eq("resume_exp7_miss", bus.miss, 1);

        // Attract clears every hole and lights all LEDs.
        step(1'b0, 1'b1, 4'd2, '0);
        check_eq("pre_attr_led", bus.led, 10'h002);
        bus.mode = 2'b00;
        step(1'b0, 1'b0, 4'd0, '0);
        check_eq("attr_led", bus.led, 10'h3FF);
        check_eq("attr_cnt", bus.active_cnt, 0);
        bus.mode = 2'b11;
        step(1'b1, 1'b1, 4'd4, 10'h008);
        check_eq("attr11_led", bus.led, 10'h3FF);
        check_eq("attr11_hit", bus.hit, 0);
        bus.mode = 2'b01;
        step(1'b0, 1'b0, 4'd0, '0);
        check_eq("post_attr_led", bus.led, 0);
        check_eq("post_attr_cnt", bus.active_cnt, 0);

        // Whiff on a DOWN hole, then whiff alongside a real hit.
        step(1'b0, 1'b0, 4'd0, 10'h080);
        check_eq("whiff7", bus.whiff, WHIFF_EXP);
        check_eq("whiff7_hit", bus.hit, 0);
        step(1'b0, 1'b0, 4'd0, '0);
        check_eq("whiff7_once", bus.whiff, 0);
        step(1'b0, 1'b1, 4'd1, '0);
        step(1'b0, 1'b0, 4'd0, 10'h081);
        check_eq("whiff_mix_hit", bus.hit, 1);
        check_eq("whiff_mix_whiff", bus.whiff, WHIFF_EXP);

        // Asynchronous reset mid-game clears outputs without a clock edge.
        step(1'b0, 1'b1, 4'd4, '0);
        check_eq("pre_rst_led", bus.led, 10'h009);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_led", bus.led, 0);
        check_eq("mid_rst_cnt", bus.active_cnt, 0);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 4'd0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mole_field_ctrl.md
Name: mole_field_ctrl

Overview:
- Parametrised successor to the hamster LED decoder: drives NUM_HOLES mole LEDs.
- Each hole has its own up/down/flash state and lifetime timer, so several moles can be up at once, expire, or be hit independently.
- Sits between the random hole selector (sel/spawn) and the LED pins; button hits and expiries feed the score logic.
- Game mode input selects normal play, frozen/blank or all-on attract display.

Parameters:
- NUM_HOLES, 10, number of holes/LEDs (1..15).
- SEL_W, 4, width of sel; must satisfy 2^SEL_W > NUM_HOLES.
- POP_TICKS, 8, ticks a mole stays up before it is missed (>=1).
- FLASH_TICKS, 4, ticks a hit hole flashes before returning to DOWN (>=1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- tick  in  1  one-cycle game-time enable; all timers advance only on tick.
- mode  in  2  00 attract, 01 play, 10 freeze, 11 treated as attract.
- sel  in  SEL_W  hole number, 1..NUM_HOLES; 0 and >NUM_HOLES are invalid.
- spawn  in  1  one-cycle request to raise hole sel.
- btn  in  NUM_HOLES  debounced one-cycle hit pulses, bit i = hole i.
- led  out  NUM_HOLES  registered LED drive, 1 = lit.
- hit  out  1  one-cycle pulse: at least one up mole was hit this cycle.
- miss  out  1  one-cycle pulse: at least one mole expired this cycle.
- whiff  out  1  one-cycle pulse: button on a non-UP hole (optional feature).
- active_cnt  out  SEL_W  number of holes currently UP.

Behaviour:
- Reset (async, rst_n=0): all holes DOWN, timers 0, flash phase 0; led=0, hit=miss=whiff=0, active_cnt=0.
- Per-hole FSM: DOWN, UP, FLASH. All outputs are registered with 1-cycle latency from inputs to led and pulses.
- Play mode (01):
  - spawn with valid sel on a DOWN hole: hole sel-1 goes to UP and its timer loads POP_TICKS.
  - spawn with invalid sel, or on an UP/FLASH hole: ignored, no state change.
  - UP: on each tick the timer decrements. A tick with timer==1 moves the hole to DOWN and pulses miss.
  - UP with btn[i]=1: hole goes to FLASH, timer loads FLASH_TICKS, hit pulses. If this coincides with expiry, the hit wins and miss does not pulse for that hole.
  - FLASH: on each tick the timer decrements and led toggles. At timer==1 with a tick the hole goes to DOWN. Spawn onto a FLASH hole is ignored.
  - led[i]: UP=1, DOWN=0, FLASH=flash phase (starts at 1 on entry, toggles each tick).
  - Multiple holes may hit or expire in the same cycle: single hit/miss pulse each. Counting multiple events is the score block's job via active_cnt deltas.
- Freeze mode (10): led=0; all FSMs and timers hold; spawn and btn ignored; no pulses.
- Attract mode (00/11): led all ones; every hole is forced to DOWN with timers cleared; spawn and btn ignored; no pulses.
- Mode change takes effect on the next clock edge. Returning from freeze to play resumes the exact prior state.
- active_cnt: registered count of UP holes after this cycle's updates; never exceeds NUM_HOLES.
- Reset mid-game: immediate clear regardless of mode or tick.

Optional Feature:
- Macro: MOLE_WHIFF_PENALTY_EN.
- Defined: whiff pulses one cycle when, in play mode, any btn[i]=1 with hole i in DOWN or FLASH. An UP hole hit in the same cycle does not suppress whiff from other holes.
- Undefined: whiff is tied to 0 and no whiff logic is generated.

Test Plan:
- Reset then mode=01, sel=3, spawn, then 8 ticks with no btn -> led=10'b0000000100 after 1 cycle, active_cnt=1; after the 8th tick led=0 and miss pulses exactly once.
- Spawn sel=5, then btn[4] after 2 ticks -> hit pulse; led[4] shows 1,0,1,0 across the 4 FLASH ticks, then DOWN; no miss.
- btn[2] in the same cycle as the expiring tick of UP hole 2 -> hit=1, miss=0, hole 2 goes to FLASH.
- Spawn sel=0, sel=11, and sel=3 while hole 3 is already UP -> no state change, active_cnt unchanged.
- Two moles UP, mode=10 for 5 ticks, then mode=01 -> led=0 during freeze with timers unchanged; remaining lifetime is preserved after resume. mode=00 -> led=all ones, active_cnt=0.
- With MOLE_WHIFF_PENALTY_EN, btn[7] on a DOWN hole -> whiff=1 for one cycle. Without the macro, whiff stays 0.
